// File: rtl/fb_pkg.sv
// fb_pkg: shared defaults and enums for the framebuffer arbiter.
// Holds width/depth defaults, RAM owner tags and clear-engine states.
package fb_pkg;

   localparam int FB_ADDR_W = 19;
   localparam int FB_DATA_W = 12;
   localparam int FB_DEPTH  = 307200;

   // Who owns the RAM read data returning next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_HOST = 2'd2,
      OWN_HERR = 2'd3
   } owner_e;

   typedef enum logic [1:0] {
      CLR_IDLE = 2'd0,
      CLR_FILL = 2'd1,
      CLR_DONE = 2'd2
   } clr_state_e;

endpackage

// File: rtl/fb_clear_engine.sv
// fb_clear_engine: fills the framebuffer with one colour, one word per won slot.
// Ports: start_i/color_i (color sampled at start), win_i (slot granted),
// req_o/addr_o/data_o (write request), busy_o (FILL+DONE), done_o (1-cycle pulse).
module fb_clear_engine
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W,
   parameter int DEPTH  = FB_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [DATA_W-1:0] color_i,
   input  logic              win_i,
   output logic              req_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [DATA_W-1:0] color_q;
   logic              busy_q;
   logic              done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
         color_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            CLR_IDLE: begin
               if (start_i) begin
                  state_q <= CLR_FILL;
                  cnt_q   <= '0;
                  color_q <= color_i;
                  busy_q  <= 1'b1;
               end
            end
            CLR_FILL: begin
               // counter moves only on slots actually granted
               if (win_i) begin
                  if (cnt_q == LAST) begin
                     state_q <= CLR_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            CLR_DONE: begin
               state_q <= CLR_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: state_q <= CLR_IDLE;
         endcase
      end
   end

   assign req_o  = (state_q == CLR_FILL);
   assign addr_o = cnt_q;
   assign data_o = color_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter (display > host/clear RR).
// Ports: disp_* read port, host_* read/write port, clr_* fill engine, ram_* RAM.
// Optional clear engine is built when FB_CLEAR_EN is defined.
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W,
   parameter int DEPTH  = FB_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_err,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic              clr_req;
   logic              clr_win;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] clr_data;

   logic              host_oob;
   logic              host_sel;
   logic              clr_sel;
   logic              rr_d, rr_q;
   owner_e            tag_d, tag_q;
   logic [ADDR_W-1:0] addr_q;

`ifdef FB_CLEAR_EN
   fb_clear_engine #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_clr (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(clr_start),
      .color_i(clr_color),
      .win_i  (clr_win),
      .req_o  (clr_req),
      .addr_o (clr_addr),
      .data_o (clr_data),
      .busy_o (clr_busy),
      .done_o (clr_done)
   );
`else
   logic unused_clr;
   assign unused_clr = ^{clr_start, clr_color, clr_win};
   assign clr_req    = 1'b0;
   assign clr_addr   = '0;
   assign clr_data   = '0;
   assign clr_busy   = 1'b0;
   assign clr_done   = 1'b0;
`endif

   assign host_oob = 32'(host_addr) >= 32'(DEPTH);

   // rr_q=1 means clear is favoured on the next contested slot
   always_comb begin
      host_sel = 1'b0;
      clr_sel  = 1'b0;
      if (rst_n && !disp_req) begin
         if (host_req && clr_req) begin
            host_sel = !rr_q;
            clr_sel  = rr_q;
         end else begin
            host_sel = host_req;
            clr_sel  = clr_req;
         end
      end
   end

   always_comb begin
      ram_addr  = addr_q;
      ram_we    = 1'b0;
      ram_wdata = '0;
      tag_d     = OWN_NONE;
      rr_d      = rr_q;
      if (rst_n && disp_req) begin
         ram_addr = disp_addr;
         tag_d    = OWN_DISP;
      end else if (host_sel) begin
         ram_addr  = host_addr;
         ram_we    = host_we && !host_oob;
         ram_wdata = host_wdata;
         rr_d      = 1'b1;
         if (!host_we) tag_d = host_oob ? OWN_HERR : OWN_HOST;
      end else if (clr_sel) begin
         ram_addr  = clr_addr;
         ram_we    = 1'b1;
         ram_wdata = clr_data;
         rr_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q  <= OWN_NONE;
         rr_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         tag_q  <= tag_d;
         rr_q   <= rr_d;
         addr_q <= ram_addr;
      end
   end

   assign clr_win     = clr_sel;
   assign host_gnt    = host_sel;
   assign host_err    = host_sel && host_oob;
   assign disp_valid  = (tag_q == OWN_DISP);
   assign disp_data   = disp_valid ? ram_rdata : '0;
   assign host_rvalid = (tag_q == OWN_HOST) || (tag_q == OWN_HERR);
   assign host_rdata  = (tag_q == OWN_HOST) ? ram_rdata : '0;

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, meaning framebuffer address width.
REQ-002 The block SHALL have parameter DATA_W, default 12, meaning pixel width (RGB444).
REQ-003 The block SHALL have parameter DEPTH, default 307200, meaning framebuffer words (640x480).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- disp_req in 1: display pixel read request.
- disp_addr in ADDR_W: display read address.
- disp_valid out 1: disp_data valid.
- disp_data out DATA_W: display read data.
- host_req in 1: host access request; held until granted.
- host_we in 1: host write (1) or read (0).
- host_addr in ADDR_W: host address.
- host_wdata in DATA_W: host write data.
- host_gnt out 1: host access accepted this cycle.
- host_rvalid out 1: host_rdata valid.
- host_rdata out DATA_W: host read data.
- host_err out 1: out-of-range host address accepted.
- clr_start in 1: start screen clear (FB_CLEAR_EN only).
- clr_color in DATA_W: clear fill value, sampled at start.
- clr_busy out 1: clear in progress.
- clr_done out 1: one-cycle clear completion pulse.
- ram_we out 1: RAM write enable.
- ram_addr out ADDR_W: RAM address.
- ram_wdata out DATA_W: RAM write data.
- ram_rdata in DATA_W: RAM read data; one-cycle synchronous latency.

Function
REQ-006 The block SHALL issue exactly one RAM access per cycle, priority: display > host/clear, with host and clear alternating round-robin when both pending.
REQ-007 The block SHALL serve disp_req unconditionally; disp_valid SHALL rise exactly 1 cycle after disp_req, carrying ram_rdata.
REQ-008 The block SHALL assert host_gnt combinationally in the cycle the host access is driven to RAM; host_gnt low while disp_req high.
REQ-009 The block SHALL assert host_rvalid 1 cycle after a granted host read; granted writes produce no rvalid.
REQ-010 The block SHALL grant host_addr >= DEPTH but suppress ram_we and pulse host_err in the grant cycle; a read returns rvalid with data 0.
REQ-011 The block SHALL register a 2-bit owner tag per access to route returned data; ram_we SHALL be 0 in non-write cycles and ram_addr hold its last value when idle.
REQ-012 The clear engine SHALL use states IDLE -> FILL -> DONE -> IDLE; IDLE->FILL on clr_start; FILL writes clr_color at counter 0..DEPTH-1, advancing only on cycles it wins the port; FILL->DONE after writing DEPTH-1; DONE lasts 1 cycle, pulses clr_done.
REQ-013 The block SHALL ignore clr_start while clr_busy; clr_busy high in FILL and DONE.
REQ-014 Host writes during clear SHALL land normally and may be overwritten by later clear writes.

Reset
REQ-015 On rst_n low the block SHALL asynchronously clear all outputs, tags, round-robin pointer (host first), clear FSM (IDLE) and counter to 0; reset mid-clear abandons it without clr_done.

Configuration
REQ-016 With FB_CLEAR_EN defined the clear engine SHALL be present; without it clr_busy and clr_done SHALL tie to 0, clr_start/clr_color SHALL be ignored, and the host SHALL get every non-display slot.

Structure
REQ-017 Package fb_pkg SHALL hold ADDR_W/DATA_W/DEPTH defaults and the owner-tag and clear-state enums.
REQ-018 The clear engine SHALL be sub-module fb_clear_engine.

Verification
REQ-019 disp_req every cycle, host_req=1 write addr 5 -> host_gnt stays 0 until disp_req drops, then 1 cycle gnt, RAM[5] written.
REQ-020 host read addr 100 (RAM=0xABC), no display -> gnt cycle N, host_rvalid with 0xABC at N+1.
REQ-021 host write addr 307200 -> gnt and host_err pulse, ram_we 0.
REQ-022 FB_CLEAR_EN, DEPTH=16, clr_start color 0xF00, host idle -> 16 writes 0..15, clr_done 1 cycle later, busy drops.
REQ-023 clear running with continuous host_req -> host/clear alternate slots; rst_n low mid-clear -> busy 0, no clr_done.
REQ-024 disp_req alternating with host reads -> disp_valid/host_rvalid never both set, data routed to correct port.
